// File: rtl/gpio_bank.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_bank
//  Description : Memory-mapped N-pin GPIO bank on the M-stage data bus.
//                Per-pin direction, atomic set/clear/toggle of the output
//                register, synchronised pad inputs and, when the macro
//                GPIO_BANK_IRQ_EN is defined, rising/falling edge detection
//                with write-1-to-clear pending bits and a level interrupt.
//                Read data is combinational on A.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_bank #(
    parameter int          N_PINS      = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h80000100,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              WE,
    input  logic [31:0]       A,
    input  logic [31:0]       WD,
    output logic [31:0]       RD,
    input  logic [N_PINS-1:0] gpio_in,
    output logic [N_PINS-1:0] gpio_out,
    output logic [N_PINS-1:0] gpio_oe,
    output logic              irq
);

    // Register indices (A[5:2])
    localparam logic [3:0] c_IDX_DATA_OUT = 4'h0;
    localparam logic [3:0] c_IDX_DIR      = 4'h1;
    localparam logic [3:0] c_IDX_DATA_IN  = 4'h2;
    localparam logic [3:0] c_IDX_SET      = 4'h3;
    localparam logic [3:0] c_IDX_CLR      = 4'h4;
    localparam logic [3:0] c_IDX_TGL      = 4'h5;
    localparam logic [3:0] c_IDX_RISE_EN  = 4'h6;
    localparam logic [3:0] c_IDX_FALL_EN  = 4'h7;
    localparam logic [3:0] c_IDX_PENDING  = 4'h8;

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    logic              w_sel;
    logic [3:0]        w_idx;
    logic              w_wr;
    logic [N_PINS-1:0] w_wd;
    logic              w_unusedBits;

    assign w_sel = (A[31:6] == BASE_ADDR[31:6]);
    assign w_idx = A[5:2];
    assign w_wr  = WE && w_sel;
    assign w_wd  = WD[N_PINS-1:0];

    // Byte lane bits and the write-data bits above N_PINS carry no meaning here
    assign w_unusedBits = ^{A[1:0], WD};

    // ------------------------------------------------------------------------
    // Output data and direction registers
    // ------------------------------------------------------------------------
    logic [N_PINS-1:0] r_dataOut;
    logic [N_PINS-1:0] r_dir;

    // DATA_OUT: plain write plus atomic set / clear / toggle aliases
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_dataOut <= '0;
        end else if (w_wr) begin
            case (w_idx)
                c_IDX_DATA_OUT: r_dataOut <= w_wd;
                c_IDX_SET:      r_dataOut <= r_dataOut | w_wd;
                c_IDX_CLR:      r_dataOut <= r_dataOut & ~w_wd;
                c_IDX_TGL:      r_dataOut <= r_dataOut ^ w_wd;
                default:        r_dataOut <= r_dataOut;
            endcase
        end
    end

    // DIR: per-pin output enable
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_dir <= '0;
        end else if (w_wr && (w_idx == c_IDX_DIR)) begin
            r_dir <= w_wd;
        end
    end

    assign gpio_out = r_dataOut;
    assign gpio_oe  = r_dir;

    // ------------------------------------------------------------------------
    // Input synchroniser; the last stage is the architectural DATA_IN
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][N_PINS-1:0] r_sync;
    logic [N_PINS-1:0]                  w_dataIn;

    // Shift the asynchronous pads through the flop chain
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_dataIn = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Edge detection and interrupt
    // ------------------------------------------------------------------------
    logic [N_PINS-1:0] w_riseEnRd;
    logic [N_PINS-1:0] w_fallEnRd;
    logic [N_PINS-1:0] w_pendingRd;

`ifdef GPIO_BANK_IRQ_EN
    logic [N_PINS-1:0] r_riseEn;
    logic [N_PINS-1:0] r_fallEn;
    logic [N_PINS-1:0] r_pending;
    logic [N_PINS-1:0] r_prev;
    logic [N_PINS-1:0] w_rise;
    logic [N_PINS-1:0] w_fall;
    logic [N_PINS-1:0] w_clr;

    // Edge enable registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_riseEn <= '0;
            r_fallEn <= '0;
        end else if (w_wr) begin
            if (w_idx == c_IDX_RISE_EN) r_riseEn <= w_wd;
            if (w_idx == c_IDX_FALL_EN) r_fallEn <= w_wd;
        end
    end

    // Edge history: one-cycle delayed copy of DATA_IN
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_dataIn;
        end
    end

    assign w_rise = w_dataIn & ~r_prev & r_riseEn;
    assign w_fall = ~w_dataIn & r_prev & r_fallEn;
    assign w_clr  = (w_wr && (w_idx == c_IDX_PENDING)) ? w_wd : '0;

    // PENDING: new edges are OR-ed in after the W1C so a coincident edge survives
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise | w_fall;
        end
    end

    assign w_riseEnRd  = r_riseEn;
    assign w_fallEnRd  = r_fallEn;
    assign w_pendingRd = r_pending;
    assign irq         = |r_pending;
`else
    assign w_riseEnRd  = '0;
    assign w_fallEnRd  = '0;
    assign w_pendingRd = '0;
    assign irq         = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    logic [N_PINS-1:0] w_rdField;

    // Select the addressed register; write-only and unmapped offsets read 0
    always_comb begin
        w_rdField = '0;
        case (w_idx)
            c_IDX_DATA_OUT: w_rdField = r_dataOut;
            c_IDX_DIR:      w_rdField = r_dir;
            c_IDX_DATA_IN:  w_rdField = w_dataIn;
            c_IDX_RISE_EN:  w_rdField = w_riseEnRd;
            c_IDX_FALL_EN:  w_rdField = w_fallEnRd;
            c_IDX_PENDING:  w_rdField = w_pendingRd;
            default:        w_rdField = '0;
        endcase
    end

    // Zero-extend to the bus width and gate by window select
    always_comb begin
        RD = '0;
        if (w_sel) begin
            RD[N_PINS-1:0] = w_rdField;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_bank
//  Description : Scoreboard bench for gpio_bank. Stimulus queues expected
//                values; a monitor compares them when a read strobe is up.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_bank;

    localparam int          N_PINS = 8;
    localparam logic [31:0] BASE   = 32'h80000100;
    localparam int          SYNC   = 2;

    localparam logic [31:0] A_DATA_OUT = BASE + 32'h00;
    localparam logic [31:0] A_DIR      = BASE + 32'h04;
    localparam logic [31:0] A_DATA_IN  = BASE + 32'h08;
    localparam logic [31:0] A_SET      = BASE + 32'h0C;
    localparam logic [31:0] A_CLR      = BASE + 32'h10;
    localparam logic [31:0] A_TGL      = BASE + 32'h14;
    localparam logic [31:0] A_RISE_EN  = BASE + 32'h18;
    localparam logic [31:0] A_FALL_EN  = BASE + 32'h1C;
    localparam logic [31:0] A_PENDING  = BASE + 32'h20;

    localparam int K_RD  = 0;
    localparam int K_OUT = 1;
    localparam int K_OE  = 2;
    localparam int K_IRQ = 3;

    logic              CLK     = 1'b0;
    logic              reset   = 1'b1;
    logic              WE      = 1'b0;
    logic [31:0]       A       = '0;
    logic [31:0]       WD      = '0;
    logic [31:0]       RD;
    logic [N_PINS-1:0] gpio_in = '0;
    logic [N_PINS-1:0] gpio_out;
    logic [N_PINS-1:0] gpio_oe;
    logic              irq;

    gpio_bank #(
        .N_PINS      (N_PINS),
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (SYNC)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .WE       (WE),
        .A        (A),
        .WD       (WD),
        .RD       (RD),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sbQ[$];
    logic rdValid  = 1'b0;
    logic stimDone = 1'b0;
    int   nChecks  = 0;
    int   nFail    = 0;

    // Inputs change 1 ns after a rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        A  = addr;
        WD = data;
        WE = 1'b1;
        tick();
        WE = 1'b0;
    endtask

    // Hold a read for one cycle and queue what the monitor should see
    task automatic expectVal(input int kind, input logic [31:0] addr,
                             input logic [31:0] exp, input string name);
        exp_t e;
        A      = addr;
        WE     = 1'b0;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sbQ.push_back(e);
        rdValid = 1'b1;
        tick();
        rdValid = 1'b0;
    endtask

    // Monitor: compares at the falling edge, away from register updates
    initial begin : monitor
        exp_t        cur;
        logic [31:0] act;
        forever begin
            @(negedge CLK);
            if (rdValid) begin
                nChecks++;
                if (sbQ.size() == 0) begin
                    nFail++;
                    $display("FAIL sb_underflow: read strobe with nothing expected, RD=%h", RD);
                end else begin
                    cur = sbQ.pop_front();
                    case (cur.kind)
                        K_OUT:   act = 32'(gpio_out);
                        K_OE:    act = 32'(gpio_oe);
                        K_IRQ:   act = 32'(irq);
                        default: act = RD;
                    endcase
                    if (act !== cur.exp) begin
                        nFail++;
                        $display("FAIL %s: got %h, expected %h", cur.name, act, cur.exp);
                    end
                end
            end
            if (stimDone) begin
                nChecks++;
                if (sbQ.size() != 0) begin
                    nFail++;
                    $display("FAIL sb_leftover: got %0d queued entries, expected 0", sbQ.size());
                end
                $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
                $finish;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        expectVal(K_OUT, A_DATA_OUT, 32'h0, "rst_gpio_out");
        expectVal(K_OE,  A_DATA_OUT, 32'h0, "rst_gpio_oe");
        expectVal(K_IRQ, A_DATA_OUT, 32'h0, "rst_irq");
        expectVal(K_RD,  A_DATA_OUT, 32'h0, "rst_data_out");
        expectVal(K_RD,  A_DIR,      32'h0, "rst_dir");

        // Basic output and direction
        busWrite(A_DATA_OUT, 32'hA5);
        busWrite(A_DIR,      32'h0F);
        expectVal(K_OUT, A_DATA_OUT, 32'hA5, "gpio_out_a5");
        expectVal(K_OE,  A_DATA_OUT, 32'h0F, "gpio_oe_0f");
        expectVal(K_RD,  A_DATA_OUT, 32'hA5, "rd_data_out_a5");
        expectVal(K_RD,  A_DIR,      32'h0F, "rd_dir_0f");

        // Atomic set / clear / toggle: F0 -> F3 -> E3 -> 62
        busWrite(A_DATA_OUT, 32'hF0);
        busWrite(A_SET,      32'h03);
        expectVal(K_RD,  A_DATA_OUT, 32'hF3, "after_set");
        busWrite(A_CLR,      32'h10);
        busWrite(A_TGL,      32'h81);
        expectVal(K_RD,  A_DATA_OUT, 32'h62, "after_tgl");
        expectVal(K_OUT, A_DATA_OUT, 32'h62, "gpio_out_62");
        expectVal(K_RD,  A_SET,      32'h0,  "rd_wo_set");
        expectVal(K_RD,  A_TGL,      32'h0,  "rd_wo_tgl");
        busWrite(A_DATA_OUT, 32'hFFFFFF00);
        expectVal(K_RD,  A_DATA_OUT, 32'h0,  "upper_bits_dropped");
        busWrite(A_DIR,      32'h12345678);
        expectVal(K_RD,  A_DIR,      32'h78, "dir_truncated");

        // Input synchroniser latency: change after edge t, visible from t+2
        gpio_in = 8'h3C;
        tick();
        expectVal(K_RD, A_DATA_IN,        32'h00, "data_in_before_sync");
        expectVal(K_RD, A_DATA_IN,        32'h3C, "data_in_after_sync");
        expectVal(K_RD, BASE + 32'h0B,    32'h3C, "data_in_byte_lane");
        expectVal(K_RD, BASE + 32'h24,    32'h0,  "unmapped_0x24");
        busWrite(A_DATA_IN, 32'hFF);
        expectVal(K_RD, A_DATA_IN,        32'h3C, "data_in_read_only");

        // Writes outside the window do nothing and read 0
        busWrite(A_DATA_OUT, 32'h5A);
        busWrite(32'h80000000, 32'hFF);
        expectVal(K_RD, 32'h80000000, 32'h0,  "outside_rd_zero");
        expectVal(K_RD, A_DATA_OUT,   32'h5A, "outside_no_write");
        busWrite(32'h80000144, 32'hFF);
        expectVal(K_RD, A_DIR,        32'h78, "above_window_no_write");

`ifdef GPIO_BANK_IRQ_EN
        // Pin1 high and settled before edges are enabled
        gpio_in = 8'h02;
        repeat (4) tick();
        busWrite(A_RISE_EN, 32'h01);
        busWrite(A_FALL_EN, 32'h02);
        expectVal(K_RD, A_RISE_EN, 32'h01, "rise_en_rb");
        expectVal(K_RD, A_PENDING, 32'h00, "no_retro_flag");

        // Pin0 rises and pin1 falls after edge t; irq appears at edge t+3
        gpio_in = 8'h01;
        tick();
        tick();
        expectVal(K_IRQ, A_PENDING, 32'h0,  "irq_not_yet");
        expectVal(K_IRQ, A_PENDING, 32'h1,  "irq_raised");
        expectVal(K_RD,  A_PENDING, 32'h03, "pending_03");
        gpio_in = 8'h00;
        repeat (4) tick();
        expectVal(K_RD,  A_PENDING, 32'h03, "pending_held");
        busWrite(A_PENDING, 32'h01);
        expectVal(K_RD,  A_PENDING, 32'h02, "w1c_bit0");
        expectVal(K_IRQ, A_PENDING, 32'h1,  "irq_still_high");
        busWrite(A_PENDING, 32'h02);
        expectVal(K_IRQ, A_PENDING, 32'h0,  "irq_cleared");
        expectVal(K_RD,  A_PENDING, 32'h00, "pending_empty");

        // Edge arriving in the same cycle as its W1C stays pending
        gpio_in = 8'h01;
        repeat (4) tick();
        gpio_in = 8'h00;
        repeat (4) tick();
        expectVal(K_RD, A_PENDING, 32'h01, "pending_preset");
        gpio_in = 8'h01;
        tick();
        tick();
        busWrite(A_PENDING, 32'h01);
        expectVal(K_RD, A_PENDING, 32'h01, "set_wins_over_clr");
        busWrite(A_PENDING, 32'h01);
        expectVal(K_RD, A_PENDING, 32'h00, "w1c_after_collision");

        // Pins high through reset, then enable rising edges: nothing flagged
        gpio_in = 8'hFF;
        reset   = 1'b1;
        repeat (2) tick();
        reset   = 1'b0;
        expectVal(K_RD, A_RISE_EN, 32'h00, "rise_en_reset");
        repeat (4) tick();
        busWrite(A_RISE_EN, 32'hFF);
        repeat (3) tick();
        expectVal(K_RD,  A_PENDING, 32'h00, "no_spurious_pending");
        expectVal(K_IRQ, A_PENDING, 32'h0,  "no_spurious_irq");
`else
        // Edge registers absent: read 0, ignore writes, irq tied low
        busWrite(A_RISE_EN, 32'hFF);
        busWrite(A_FALL_EN, 32'hFF);
        busWrite(A_PENDING, 32'hFF);
        gpio_in = 8'hC3;
        repeat (4) tick();
        gpio_in = 8'h00;
        repeat (4) tick();
        expectVal(K_RD,  A_RISE_EN, 32'h0, "no_irq_rise_en");
        expectVal(K_RD,  A_FALL_EN, 32'h0, "no_irq_fall_en");
        expectVal(K_RD,  A_PENDING, 32'h0, "no_irq_pending");
        expectVal(K_IRQ, A_PENDING, 32'h0, "no_irq_irq");
`endif

        // Reset overriding a same-cycle DATA_OUT write
        busWrite(A_DIR,      32'hFF);
        busWrite(A_DATA_OUT, 32'h33);
        expectVal(K_OUT, A_DATA_OUT, 32'h33, "pre_reset_out");
        A     = A_DATA_OUT;
        WD    = 32'hFF;
        WE    = 1'b1;
        reset = 1'b1;
        tick();
        WE    = 1'b0;
        reset = 1'b0;
        expectVal(K_OUT, A_DATA_OUT, 32'h0, "reset_wr_gpio_out");
        expectVal(K_OE,  A_DATA_OUT, 32'h0, "reset_wr_gpio_oe");
        expectVal(K_IRQ, A_DATA_OUT, 32'h0, "reset_wr_irq");
        expectVal(K_RD,  A_DATA_OUT, 32'h0, "reset_wr_data_out");

        tick();
        stimDone = 1'b1;
    end

endmodule
`default_nettype wire
